// File: rtl/multi_alarm_ctrl.sv
// N-channel alarm scheduler: per-channel compare on SEC_TICK, lowest-index arbitration, dismiss/snooze/timeout.
// Latency: match sets PENDING at the next edge; ALARM_DOING rises two edges later; one IDLE cycle between rings.
// Backpressure: none; every strobe and pulse is acted on in the cycle it is presented.
module multi_alarm_ctrl #(
  parameter int N_ALARMS   = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  localparam int IW = $clog2(N_ALARMS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [16:0]         current_time,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [16:0]         wr_time,
  input  logic                wr_enable,
  input  logic                dismiss,
  input  logic                snooze,
  output logic [N_ALARMS-1:0] alarm_enable,
  output logic                alarm_doing,
  output logic [IW-1:0]       active_idx,
  output logic [2:0]          snooze_cnt,
  output logic [N_ALARMS-1:0] pending
);

  typedef enum logic {IDLE, RING} state_t;

  state_t      state;
  logic [16:0] alarm_time  [N_ALARMS];
  logic [16:0] target_time [N_ALARMS];
  logic [2:0]  snz_cnt     [N_ALARMS];
  logic [7:0]  ring_cnt;
  logic        pend_seen;   // pending was non-zero in the previous cycle

  logic                ring;
  logic                wr_ok;
  logic                wr_hits_active;
  logic                end_dismiss;
  logic                end_snooze;
  logic [2:0]          act_cnt;
  logic [N_ALARMS-1:0] match;
  logic [N_ALARMS-1:0] wr_mask;
  logic [N_ALARMS-1:0] pend_eff;
  logic [IW-1:0]       sel_idx;
  logic [6:0]          mm_sum;
  logic [5:0]          snz_mm;
  logic [4:0]          snz_hh;
  logic [16:0]         snz_time;

  assign ring           = (state == RING);
  assign wr_ok          = wr_en && (wr_time[16:12] <= 5'd23) && (wr_time[11:6] <= 6'd59) &&
                          (wr_time[5:0] <= 6'd59) && (32'(wr_idx) < N_ALARMS);
  assign wr_hits_active = ring && wr_ok && (wr_idx == active_idx);
  assign act_cnt        = snz_cnt[active_idx];
  // A channel being rewritten this cycle loses its pending bit, so it must not be granted.
  assign pend_eff       = pending & ~wr_mask;

  // One-hot mask of the channel accepted by a valid write.
  always_comb begin
    wr_mask = '0;
    if (wr_ok) wr_mask[wr_idx] = 1'b1;
  end

  // Per-channel time match on the second tick; the ringing channel is excluded from re-firing.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      match[i] = sec_tick && alarm_enable[i] && (current_time == target_time[i]) &&
                 !(ring && (active_idx == IW'(i)));
    end
  end

  // Lowest-index grant among pending channels.
  always_comb begin
    sel_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (pend_eff[i]) sel_idx = IW'(i);
    end
  end

  // Snoozed target: minutes advance with carry into hours, seconds kept, 23h wraps to 00h.
  always_comb begin
    mm_sum = 7'(current_time[11:6]) + 7'(SNOOZE_MIN);
    snz_hh = current_time[16:12];
    snz_mm = 6'(mm_sum);
    if (mm_sum >= 7'd60) begin
      snz_mm = 6'(mm_sum - 7'd60);
      snz_hh = (current_time[16:12] == 5'd23) ? 5'd0 : current_time[16:12] + 5'd1;
    end
    snz_time = {snz_hh, snz_mm, current_time[5:0]};
  end

  // How a ring ends this cycle: write-to-active or DISMISS first, then SNOOZE, then timeout.
  always_comb begin
    end_dismiss = 1'b0;
    end_snooze  = 1'b0;
    if (ring) begin
      if (wr_hits_active || dismiss) begin
        end_dismiss = 1'b1;
      end else if (snooze) begin
        if (act_cnt < 3'(MAX_SNOOZE)) end_snooze = 1'b1;
        else                          end_dismiss = 1'b1;
      end else if (sec_tick && (ring_cnt == 8'(RING_SEC - 1))) begin
        end_dismiss = 1'b1;
      end
    end
  end

  // Channel storage: match sets pending, ring end services the active channel, a write overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_enable <= '0;
      pending      <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        alarm_time[i]  <= '0;
        target_time[i] <= '0;
        snz_cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (match[i]) pending[i] <= 1'b1;
        if (ring && (active_idx == IW'(i))) begin
          if (end_dismiss) begin
            pending[i]     <= 1'b0;
            target_time[i] <= alarm_time[i];
            snz_cnt[i]     <= '0;
          end else if (end_snooze) begin
            pending[i]     <= 1'b0;
            target_time[i] <= snz_time;
            snz_cnt[i]     <= snz_cnt[i] + 3'd1;
          end
        end
        if (wr_mask[i]) begin
          alarm_time[i]   <= wr_time;
          target_time[i]  <= wr_time;
          alarm_enable[i] <= wr_enable;
          snz_cnt[i]      <= '0;
          pending[i]      <= 1'b0;
        end
      end
    end
  end

  // IDLE/RING sequencer with registered ring status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ring_cnt    <= '0;
      pend_seen   <= 1'b0;
      alarm_doing <= 1'b0;
      active_idx  <= '0;
      snooze_cnt  <= '0;
    end else begin
      pend_seen <= |pending;
      case (state)
        IDLE: begin
          if (pend_seen && (|pend_eff)) begin
            state       <= RING;
            active_idx  <= sel_idx;
            ring_cnt    <= '0;
            alarm_doing <= 1'b1;
            snooze_cnt  <= snz_cnt[sel_idx];
          end
        end
        RING: begin
          if (sec_tick) ring_cnt <= ring_cnt + 8'd1;
          if (end_dismiss || end_snooze) begin
            state       <= IDLE;
            alarm_doing <= 1'b0;
            active_idx  <= '0;
            snooze_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: directed alarm scenarios followed by randomized traffic.
// Every cycle the DUT outputs are compared against a behavioural model of the alarm rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_multi_alarm_ctrl;
  localparam int N          = 4;
  localparam int RING_SEC   = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        sec_tick;
  logic [16:0] current_time;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [16:0] wr_time;
  logic        wr_enable;
  logic        dismiss;
  logic        snooze;
  logic [N-1:0] alarm_enable;
  logic        alarm_doing;
  logic [1:0]  active_idx;
  logic [2:0]  snooze_cnt;
  logic [N-1:0] pending;

  always #5 clk = ~clk;

  multi_alarm_ctrl #(
    .N_ALARMS(N), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .current_time(current_time),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time), .wr_enable(wr_enable),
    .dismiss(dismiss), .snooze(snooze), .alarm_enable(alarm_enable),
    .alarm_doing(alarm_doing), .active_idx(active_idx), .snooze_cnt(snooze_cnt),
    .pending(pending)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-channel alarm A, target T, snooze count C, pending P, enable.
  logic [16:0]  mA [N];
  logic [16:0]  mT [N];
  int           mC [N];
  logic [N-1:0] mP;
  logic [N-1:0] mEn;
  logic         mRing;
  int           mAct;
  int           mTicks;
  logic         mPrevAny;
  logic [16:0]  ct;

  function automatic logic [16:0] mk(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [16:0] add_sec(input logic [16:0] t, input int n);
    int s;
    s = (int'(t[16:12]) * 3600 + int'(t[11:6]) * 60 + int'(t[5:0]) + n) % 86400;
    return mk(s / 3600, (s / 60) % 60, s % 60);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the alarm rules, then compare all outputs.
  task automatic step(input logic t, input logic [16:0] tm, input logic we, input logic [1:0] wi,
                      input logic [16:0] wt, input logic wen, input logic dis, input logic snz,
                      input logic rst);
    logic         vw;
    logic         start;
    logic [N-1:0] m;
    logic [N-1:0] wmask;
    logic [N-1:0] eff;
    int           action;
    int           sel;
    reset = rst; sec_tick = t; current_time = tm; wr_en = we; wr_idx = wi;
    wr_time = wt; wr_enable = wen; dismiss = dis; snooze = snz;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mA[i] = '0; mT[i] = '0; mC[i] = 0;
      end
      mP = '0; mEn = '0; mRing = 1'b0; mAct = 0; mTicks = 0; mPrevAny = 1'b0;
    end else begin
      vw = we && (wt[16:12] <= 23) && (wt[11:6] <= 59) && (wt[5:0] <= 59);
      wmask = '0;
      if (vw) wmask[wi] = 1'b1;
      for (int i = 0; i < N; i++)
        m[i] = t && mEn[i] && (tm == mT[i]) && !(mRing && (mAct == i));
      action = 0;  // 1 = dismiss, 2 = snooze
      if (mRing) begin
        if ((vw && (int'(wi) == mAct)) || dis) action = 1;
        else if (snz) action = (mC[mAct] < MAX_SNOOZE) ? 2 : 1;
        else if (t && (mTicks + 1 == RING_SEC)) action = 1;
      end
      start = 1'b0;
      sel = 0;
      eff = mP & ~wmask;
      if (!mRing && mPrevAny && (eff != 0)) begin
        start = 1'b1;
        for (int i = N - 1; i >= 0; i--) if (eff[i]) sel = i;
      end
      mPrevAny = (mP != 0);
      mP = mP | m;
      if (action == 1) begin
        mP[mAct] = 1'b0; mT[mAct] = mA[mAct]; mC[mAct] = 0;
      end else if (action == 2) begin
        mP[mAct] = 1'b0; mT[mAct] = add_sec(tm, SNOOZE_MIN * 60); mC[mAct] = mC[mAct] + 1;
      end
      if (vw) begin
        mA[wi] = wt; mT[wi] = wt; mEn[wi] = wen; mC[wi] = 0; mP[wi] = 1'b0;
      end
      if (mRing) begin
        if (t) mTicks++;
        if (action != 0) mRing = 1'b0;
      end else if (start) begin
        mRing = 1'b1; mAct = sel; mTicks = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("model_doing",   32'(alarm_doing),  32'(mRing));
    chk("model_idx",     32'(active_idx),   mRing ? mAct : 0);
    chk("model_snzcnt",  32'(snooze_cnt),   mRing ? mC[mAct] : 0);
    chk("model_pending", 32'(pending),      32'(mP));
    chk("model_enable",  32'(alarm_enable), 32'(mEn));
  endtask

  task automatic idle();
    step(1'b0, ct, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic tick(input logic [16:0] tm);
    ct = tm;
    step(1'b1, ct, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic fire(input logic [16:0] tm);
    tick(tm); idle(); idle();
  endtask
  task automatic wr(input logic [1:0] idx, input logic [16:0] tm, input logic en);
    step(1'b0, ct, 1'b1, idx, tm, en, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_dismiss();
    step(1'b0, ct, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic do_snooze();
    step(1'b0, ct, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic do_reset();
    step(1'b0, ct, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic        r_t, r_we, r_wen, r_dis, r_snz, r_rst, quiet;
    logic [1:0]  r_wi;
    logic [16:0] r_wt;
    int          kind;

    reset = 1'b1; sec_tick = 1'b0; current_time = '0; wr_en = 1'b0; wr_idx = '0;
    wr_time = '0; wr_enable = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    ct = mk(6, 59, 59);
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_doing",   32'(alarm_doing),  0);
    chk("rst_pending", 32'(pending),      0);
    chk("rst_enable",  32'(alarm_enable), 0);

    // Single channel fires with two-edge latency
    wr(2'd1, mk(7, 0, 0), 1'b1);
    tick(mk(7, 0, 0));
    chk("t1_pend",   32'(pending), 32'b0010);
    chk("t1_e0",     32'(alarm_doing), 0);
    idle();
    chk("t1_e1",     32'(alarm_doing), 0);
    idle();
    chk("t1_doing",  32'(alarm_doing), 1);
    chk("t1_idx",    32'(active_idx), 1);
    do_dismiss();
    chk("t1_off",    32'(alarm_doing), 0);
    chk("t1_clr",    32'(pending), 0);

    // Two channels on the same tick: lowest index first, then the other after one IDLE cycle
    wr(2'd0, mk(6, 30, 0), 1'b1);
    wr(2'd2, mk(6, 30, 0), 1'b1);
    tick(mk(6, 30, 0));
    chk("t2_pend",   32'(pending), 32'b0101);
    idle(); idle();
    chk("t2_idx0",   32'(active_idx), 0);
    chk("t2_doing0", 32'(alarm_doing), 1);
    do_dismiss();
    chk("t2_gap",    32'(alarm_doing), 0);
    chk("t2_left",   32'(pending), 32'b0100);
    idle();
    chk("t2_doing2", 32'(alarm_doing), 1);
    chk("t2_idx2",   32'(active_idx), 2);
    do_dismiss();

    // Snooze across midnight
    wr(2'd3, mk(23, 58, 10), 1'b1);
    fire(mk(23, 58, 10));
    chk("t3_idx",    32'(active_idx), 3);
    do_snooze();
    chk("t3_off",    32'(alarm_doing), 0);
    tick(mk(0, 3, 9));
    chk("t3_early",  32'(pending), 0);
    fire(mk(0, 3, 10));
    chk("t3_ring",   32'(alarm_doing), 1);
    chk("t3_cnt",    32'(snooze_cnt), 1);

    // Snooze limit: the fourth snooze acts as dismiss and restores the alarm time
    do_snooze(); fire(mk(0, 8, 10));
    chk("t4_cnt2",   32'(snooze_cnt), 2);
    do_snooze(); fire(mk(0, 13, 10));
    chk("t4_cnt3",   32'(snooze_cnt), 3);
    do_snooze();
    chk("t4_off",    32'(alarm_doing), 0);
    chk("t4_cnt0",   32'(snooze_cnt), 0);
    tick(mk(0, 18, 10));
    chk("t4_noresch", 32'(pending), 0);
    fire(mk(23, 58, 10));
    chk("t4_back",   32'(alarm_doing), 1);
    chk("t4_cntrst", 32'(snooze_cnt), 0);

    // Ring timeout on the RING_SEC-th tick
    for (int k = 1; k < RING_SEC; k++) tick(add_sec(mk(23, 58, 10), k));
    chk("t5_still",  32'(alarm_doing), 1);
    tick(add_sec(mk(23, 58, 10), RING_SEC));
    chk("t5_tmo",    32'(alarm_doing), 0);

    // Invalid writes ignored; reset mid-ring clears everything
    wr(2'd0, mk(24, 0, 0), 1'b0);
    chk("t6_hh",     32'(alarm_enable), 32'b1111);
    wr(2'd2, mk(12, 60, 0), 1'b0);
    chk("t6_mm",     32'(alarm_enable), 32'b1111);
    fire(mk(7, 0, 0));
    chk("t6_ring",   32'(alarm_doing), 1);
    do_reset();
    chk("t6_doing",  32'(alarm_doing), 0);
    chk("t6_idx",    32'(active_idx), 0);
    chk("t6_pend",   32'(pending), 0);
    chk("t6_en",     32'(alarm_enable), 0);

    // Randomized traffic; every third block of cycles has no user actions so timeouts occur
    for (int cyc = 0; cyc < 4500; cyc++) begin
      quiet = (((cyc / 300) % 3) == 2);
      r_t = ($urandom_range(0, quiet ? 1 : 2) == 0);
      if (r_t) begin
        if ($urandom_range(0, 3) == 0) ct = mT[$urandom_range(0, N - 1)];
        else                           ct = add_sec(ct, 1);
      end
      r_we = !r_t && ($urandom_range(0, 19) == 0);
      r_wi = 2'($urandom_range(0, N - 1));
      kind = int'($urandom_range(0, 7));
      case (kind)
        0:       r_wt = mk(int'($urandom_range(24, 31)), int'($urandom_range(0, 59)), 0);
        1:       r_wt = mk(int'($urandom_range(0, 23)), int'($urandom_range(60, 63)), 0);
        2:       r_wt = mk(int'($urandom_range(0, 23)), 0, int'($urandom_range(60, 63)));
        default: r_wt = add_sec(ct, int'($urandom_range(1, 6)));
      endcase
      r_wen = ($urandom_range(0, 3) != 0);
      r_dis = !quiet && ($urandom_range(0, 14) == 0);
      r_snz = !quiet && ($urandom_range(0, 9) == 0);
      r_rst = ($urandom_range(0, 999) == 0);
      step(r_t, ct, r_we, r_wi, r_wt, r_wen, r_dis, r_snz, r_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
